// File: rtl/arb_pkg.sv
// arb_pkg -- shared types and constants for the 4-way round-robin arbiter.
//   arb_state_e : arbiter FSM state encoding (IDLE, GRANT)
//   NUM_REQ     : number of requesters (4)
//   ID_W        : width of a requester index (2)
//   rr_pick()   : round-robin winner search starting at a pointer
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // First requester at or above ptr, wrapping 3 -> 0. Returns ptr when no
  // request is set; callers only use the result when req is non-zero.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] idx;
    rr_pick = ptr;
    // Walk from farthest to nearest so the nearest hit is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + ID_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/arb_gnt_dec.sv
// arb_gnt_dec -- binary to one-hot grant decode (combinational).
//   id_i     : 2-bit requester index
//   onehot_o : 4-bit one-hot vector, bit id_i set
module arb_gnt_dec
  import arb_pkg::*;
(
  input  logic [ID_W-1:0]    id_i,
  output logic [NUM_REQ-1:0] onehot_o
);

  always_comb begin
    onehot_o       = '0;
    onehot_o[id_i] = 1'b1;
  end

endmodule

// File: rtl/rr_arb4.sv
// rr_arb4 -- 4-requester round-robin arbiter with a mandatory idle bubble
// between grants.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req       : request lines, bit i = requester i
//   done      : owner releases the resource
//   gnt       : one-hot grant, or zero
//   gnt_id    : index of current / last owner (held in IDLE)
//   gnt_valid : high when gnt is non-zero
//   timeout   : one-cycle forced-release pulse (ARB_TIMEOUT_EN only)
// Optional feature macro: ARB_TIMEOUT_EN enables the grant-length limit set
// by TIMEOUT_CYCLES (2..255).
//
// state | meaning
// IDLE  | no grant held; arbitrate any pending requests
// GRANT | grant held by gnt_id until done, owner req drop, or timeout
module rr_arb4
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid
`ifdef ARB_TIMEOUT_EN
  ,
  output logic               timeout
`endif
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_param_chk
    $error("rr_arb4: TIMEOUT_CYCLES must be in 2..255");
  end

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]   winner;
  logic              rls;
  logic              tmo_w;
  logic [NUM_REQ-1:0] dec_w;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  assign tmo_w   = (state_q == GRANT) && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign timeout = tmo_w;
`else
  assign tmo_w = 1'b0;
`endif

  assign winner = rr_pick(req, ptr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_id_q <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_id_q <= gnt_id_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_id_d = gnt_id_q;
    rls      = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d  = GRANT;
          gnt_id_d = winner;
          ptr_d    = winner + 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      GRANT: begin
        // Any combination of release causes collapses into one return to IDLE.
        rls = done | ~req[gnt_id_q] | tmo_w;
        if (rls) state_d = IDLE;
`ifdef ARB_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  arb_gnt_dec u_gnt_dec (
    .id_i     (gnt_id_q),
    .onehot_o (dec_w)
  );

  // Decoded from registered state so reset removes the grant without a clock.
  assign gnt_valid = (state_q == GRANT);
  assign gnt       = gnt_valid ? dec_w : '0;
  assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_rr_arb4.sv
module tb_rr_arb4;

  localparam int TO_CYC = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
`ifdef ARB_TIMEOUT_EN
  logic       timeout;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Reference model: owner index (-1 = none), rotation pointer, last owner,
  // cycles the current owner has held the grant.
  int m_owner, m_ptr, m_last, m_cnt;

  always #5 clk = ~clk;

  rr_arb4 #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout   (timeout)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_tmo();
    return TO_EN && (m_owner >= 0) && (m_cnt == TO_CYC - 1);
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_last  = 0;
    m_cnt   = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit found;
    found = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (m_ptr + k) % 4;
        if (!found && req[idx]) begin
          found   = 1'b1;
          m_owner = idx;
          m_last  = idx;
          m_ptr   = (idx + 1) % 4;
          m_cnt   = 0;
        end
      end
    end else if (done || !req[m_owner] || m_tmo()) begin
      m_owner = -1;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".gnt"}, 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk({tag, ".gnt_id"}, 32'(gnt_id), 32'(m_last));
    chk({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
`ifdef ARB_TIMEOUT_EN
    chk({tag, ".timeout"}, 32'(timeout), 32'(m_tmo()));
`endif
  endtask

  task automatic cycle(input logic [3:0] r, input logic d, input string tag);
    req  = r;
    done = d;
    model_step();
    @(posedge clk);
    #1;
    check_outs(tag);
  endtask

  // Asynchronous reset asserted away from the clock edge; checked before any edge.
  task automatic do_reset(input string tag);
    req   = 4'b0000;
    done  = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ids[$];
    logic prev_v;
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    model_reset();
    #2;
    check_outs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset priority, bubble, then next requester.
    cycle(4'b1111, 1'b0, "rst_pri");
    chk("rst_pri.gnt_const", 32'(gnt), 32'h1);
    cycle(4'b1111, 1'b1, "rst_bubble");
    chk("rst_bubble.gnt_const", 32'(gnt), 32'h0);
    cycle(4'b1111, 1'b0, "rst_next");
    chk("rst_next.gnt_const", 32'(gnt), 32'h2);

    // Rotation with wrap: done every third cycle.
    do_reset("rot_rst");
    prev_v = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cycle(4'b1111, (i % 3 == 2), "rot");
      if (gnt_valid && !prev_v) ids.push_back(int'(gnt_id));
      prev_v = gnt_valid;
    end
    chk("rot.count", 32'(ids.size()), 32'd5);
    for (int i = 0; i < 5 && i < ids.size(); i++)
      chk("rot.order", 32'(ids[i]), 32'(i % 4));

    // Owner drops its request; pointer then favours requester 3.
    do_reset("drop_rst");
    cycle(4'b0100, 1'b0, "drop_g2");
    chk("drop_g2.gnt_const", 32'(gnt), 32'h4);
    cycle(4'b0000, 1'b0, "drop_rel");
    chk("drop_rel.gnt_const", 32'(gnt), 32'h0);
    cycle(4'b1001, 1'b0, "drop_ptr3");
    chk("drop_ptr3.gnt_const", 32'(gnt), 32'h8);

    // Reset while granting: grant drops without a clock edge.
    do_reset("mid_rst0");
    cycle(4'b0100, 1'b0, "mid_g2");
    chk("mid_g2.gnt_const", 32'(gnt), 32'h4);
    rst_n = 1'b0;
    #1;
    chk("mid_async.gnt_const", 32'(gnt), 32'h0);
    model_reset();
    check_outs("mid_async");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b0110, 1'b0, "mid_after");
    chk("mid_after.gnt_const", 32'(gnt), 32'h2);

    // Simultaneous done and owner drop: one release, pointer moves once.
    do_reset("sim_rst");
    cycle(4'b0010, 1'b0, "sim_g1");
    cycle(4'b0000, 1'b1, "sim_rel");
    chk("sim_rel.gnt_const", 32'(gnt), 32'h0);
    cycle(4'b1111, 1'b0, "sim_next");
    chk("sim_next.gnt_const", 32'(gnt), 32'h4);
    cycle(4'b1111, 1'b1, "sim_rel2");
    cycle(4'b1111, 1'b0, "sim_next2");
    chk("sim_next2.gnt_const", 32'(gnt), 32'h8);

    // done in IDLE has no effect.
    cycle(4'b0000, 1'b1, "idle_done_a");
    cycle(4'b0000, 1'b1, "idle_done_b");
    chk("idle_done.gnt_id_hold", 32'(gnt_id), 32'd3);

    // Held single request: with the timeout feature the grant is cut after
    // TO_CYC cycles and re-granted after one bubble; without it the grant stays.
    do_reset("to_rst");
    for (int i = 0; i < 3 * (TO_CYC + 1); i++) cycle(4'b0001, 1'b0, "to_hold");

    // Randomized traffic, with occasional asynchronous reset.
    do_reset("rnd_rst");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset("rnd_arst");
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_arb4.md
RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum grant length in cycles; legal range 2..255; used only when ARB_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req, input, 4 bits: request lines; bit i is requester i.
REQ-005 SHALL have port done, input, 1 bit: the current owner releases the resource.
REQ-006 SHALL have port gnt, output, 4 bits: one-hot grant, or all zero.
REQ-007 SHALL have port gnt_id, output, 2 bits: binary index of the current or last owner.
REQ-008 SHALL have port gnt_valid, output, 1 bit: high exactly when gnt is non-zero.
REQ-009 SHALL have port timeout, output, 1 bit: one-cycle forced-release pulse; present only with ARB_TIMEOUT_EN.

Function
REQ-010 SHALL implement a 2-state FSM.
- IDLE: no grant is held.
- GRANT: a grant is held.
REQ-011 In IDLE with req != 0, SHALL pick the winner.
- Search starts at ptr and moves upward mod 4 (3 wraps to 0).
- The winner is registered into gnt_id.
- The FSM moves to GRANT.
- gnt asserts on the cycle after req is sampled, so latency is 1 cycle.
REQ-012 In IDLE with req == 0, SHALL stay in IDLE with gnt = 0.
REQ-013 In GRANT, gnt SHALL equal the one-hot decode of gnt_id.
- Bit mapping: 0->0001, 1->0010, 2->0100, 3->1000.
- No other pattern is legal.
REQ-014 On each grant, ptr SHALL update to (winner + 1) mod 4, giving round-robin fairness.
REQ-015 In GRANT, a release SHALL occur on any of these:
- done = 1;
- req[gnt_id] = 0;
- timeout, when ARB_TIMEOUT_EN is defined.
REQ-016 On release, SHALL return to IDLE, with gnt = 0 for at least one cycle (mandatory bubble) before the next grant.
REQ-017 If done and a req[gnt_id] drop occur together, SHALL treat them as a single release.
REQ-018 Requests from non-owners during GRANT SHALL be ignored; they are re-arbitrated in IDLE.
REQ-019 done asserted in IDLE SHALL have no effect.
REQ-020 gnt_id SHALL hold its last value in IDLE.

Reset
REQ-021 While rst_n = 0, SHALL asynchronously force:
- state = IDLE, ptr = 0, gnt = 0, gnt_id = 0, gnt_valid = 0;
- timeout = 0 and cycle counter = 0.
REQ-022 Reset asserted during GRANT SHALL drop gnt immediately, without waiting for clk.
REQ-023 After rst_n rises, the first arbitration SHALL give requester 0 top priority.

Configuration
REQ-024 With macro ARB_TIMEOUT_EN defined:
- an 8-bit counter clears on entry to GRANT and increments each GRANT cycle;
- when it reaches TIMEOUT_CYCLES-1, a release is forced and timeout pulses high for that one cycle.
REQ-025 With ARB_TIMEOUT_EN undefined:
- the counter and the timeout port SHALL not exist;
- a grant lasts until done or the owner's req drops.

Structure
REQ-026 Package arb_pkg SHALL hold:
- the state enum (IDLE, GRANT);
- NUM_REQ = 4;
- ID_W = 2.
REQ-027 The binary-to-one-hot grant decode SHALL be a sub-module named arb_gnt_dec (2-bit in, 4-bit out, combinational).

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Reset: after reset, req=1111 -> gnt=0001 next cycle, gnt_id=0; done -> bubble, then gnt=0010.
- Rotation: req=1111 held, done every 3rd cycle -> grant order 0,1,2,3,0 (wrap), with one idle cycle between each.
- Owner drop: grant to 2 (req=0100), then req=0000 -> gnt=0000 next cycle; then req=1001 -> gnt=1000, since ptr=3.
- Reset mid-grant: rst_n low during gnt=0100 -> gnt=0000 with no clock edge; then rst_n high, req=0110 -> gnt=0010.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): req=0001 held, done=0 -> gnt high for 4 cycles, timeout pulses on cycle 4, gnt=0 for 1 cycle, then re-granted to 0.
- Simultaneous release: done=1 and req[gnt_id]=0 in the same cycle -> exactly one release, and ptr advances once.
